// File: rtl/w_xor_descrambler_pkg.sv
// Shared constants for the x^7+x^6+1 nibble descrambler.
package w_xor_descrambler_pkg;

    localparam int unsigned SR_W   = 7;
    localparam int unsigned TAP_A  = 5;
    localparam int unsigned TAP_B  = 6;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned ERR_W  = 4;

    localparam int unsigned         LOCK_CNT_W  = 2;
    localparam logic [LOCK_CNT_W-1:0] LOCK_THRESH = 2'd2;

endpackage

// File: rtl/w_xor_descrambler_step.sv
// Single-bit descrambler step: output bit and next history for one received bit.
module w_xor_descr_step
    import w_xor_descrambler_pkg::*;
(
    input  logic            i_d,
    input  logic [SR_W-1:0] i_sr,
    output logic            o_y,
    output logic [SR_W-1:0] o_sr
);

    assign o_y  = i_d ^ i_sr[TAP_B] ^ i_sr[TAP_A];
    assign o_sr = {i_sr[SR_W-2:0], i_d};

endmodule

// File: rtl/w_xor_descrambler.sv
// Self-synchronizing x^7+x^6+1 nibble descrambler with registered valid/ready output.
// Optional parity checking is enabled by defining PARITY_CHECK_EN.
module w_xor_descrambler
    import w_xor_descrambler_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] IN_D,
    input  logic              IN_PAR,
    input  logic              IN_VALID,
    output logic              IN_READY,
    output logic [DATA_W-1:0] OUT_D,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic              OUT_LOCK,
    output logic              PAR_ERR,
    output logic [ERR_W-1:0]  ERR_CNT
);

    logic [SR_W-1:0]             r_sr;
    logic [DATA_W-1:0]           r_out_d;
    logic                        r_out_valid;
    logic                        r_out_lock;
    logic [LOCK_CNT_W-1:0]       r_lock_cnt;
    logic                        w_xfer;
    logic [DATA_W-1:0]           w_y;
    logic [DATA_W:0][SR_W-1:0]   w_sr_chain;

    assign IN_READY = !r_out_valid || OUT_READY;
    assign w_xfer   = IN_VALID && IN_READY;

    // Bit 0 is earliest on the wire, so it is shifted in first.
    assign w_sr_chain[0] = r_sr;
    for (genvar b = 0; b < DATA_W; b++) begin : g_step
        w_xor_descr_step u_step (
            .i_d  (IN_D[b]),
            .i_sr (w_sr_chain[b]),
            .o_y  (w_y[b]),
            .o_sr (w_sr_chain[b+1])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sr        <= '0;
            r_out_d     <= '0;
            r_out_valid <= 1'b0;
            r_out_lock  <= 1'b0;
            r_lock_cnt  <= '0;
        end else if (w_xfer) begin
            r_sr        <= w_sr_chain[DATA_W];
            r_out_d     <= w_y;
            r_out_valid <= 1'b1;
            r_out_lock  <= (r_lock_cnt >= LOCK_THRESH);
            if (r_lock_cnt != '1) begin
                r_lock_cnt <= r_lock_cnt + 1'b1;
            end
        end else if (OUT_READY) begin
            r_out_valid <= 1'b0;
        end
    end

    assign OUT_D     = r_out_d;
    assign OUT_VALID = r_out_valid;
    assign OUT_LOCK  = r_out_lock;

`ifdef PARITY_CHECK_EN
    logic               r_par_err;
    logic [ERR_W-1:0]   r_err_cnt;
    logic               w_par_mis;

    assign w_par_mis = (^IN_D) ^ IN_PAR;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_par_err <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_xfer) begin
            r_par_err <= w_par_mis;
            if (w_par_mis && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign PAR_ERR = r_par_err;
    assign ERR_CNT = r_err_cnt;
`else
    logic w_unused_par;

    assign w_unused_par = IN_PAR;
    assign PAR_ERR      = 1'b0;
    assign ERR_CNT      = '0;
`endif

endmodule

// File: tb/tb_w_xor_descrambler.sv
// Directed bench for w_xor_descrambler; parity expectations follow PARITY_CHECK_EN.
module tb_w_xor_descrambler;

`ifdef PARITY_CHECK_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] IN_D;
    logic       IN_PAR;
    logic       IN_VALID;
    logic       IN_READY;
    logic [3:0] OUT_D;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic       OUT_LOCK;
    logic       PAR_ERR;
    logic [3:0] ERR_CNT;

    int checks   = 0;
    int failures = 0;

    logic [6:0] scr_st;

    w_xor_descrambler dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_D      (IN_D),
        .IN_PAR    (IN_PAR),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OUT_D     (OUT_D),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_LOCK  (OUT_LOCK),
        .PAR_ERR   (PAR_ERR),
        .ERR_CNT   (ERR_CNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference x^7+x^6+1 scrambler, bit 0 first.
    task automatic scramble(input logic [3:0] p, input logic [6:0] st,
                            output logic [3:0] s, output logic [6:0] nst);
        nst = st;
        for (int b = 0; b < 4; b++) begin
            s[b] = p[b] ^ nst[6] ^ nst[5];
            nst  = {nst[5:0], s[b]};
        end
    endtask

    task automatic send_raw(input logic [3:0] d, input logic par);
        IN_D     = d;
        IN_PAR   = par;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
    endtask

    task automatic send_plain(input logic [3:0] p);
        logic [3:0] s;
        logic [6:0] nst;
        scramble(p, scr_st, s, nst);
        send_raw(s, ^s);
        scr_st = nst;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    initial begin
        logic [3:0] p, pa, pb, pc, s;
        logic [6:0] nst;

        RST       = 1'b1;
        IN_D      = '0;
        IN_PAR    = 1'b0;
        IN_VALID  = 1'b0;
        OUT_READY = 1'b0;
        scr_st    = '0;
        #1;
        chk("rst_out_d",     OUT_D,     4'h0);
        chk("rst_out_valid", OUT_VALID, 1'b0);
        chk("rst_out_lock",  OUT_LOCK,  1'b0);
        chk("rst_par_err",   PAR_ERR,   1'b0);
        chk("rst_err_cnt",   ERR_CNT,   4'h0);
        chk("rst_in_ready",  IN_READY,  1'b1);
        @(negedge CLK);
        RST       = 1'b0;
        OUT_READY = 1'b1;

        // Hand-computed: from SR=0, 0001 -> 0001, then 0000 -> 1100.
        send_raw(4'b0001, 1'b1);
        chk("dir1_d",     OUT_D,     4'b0001);
        chk("dir1_valid", OUT_VALID, 1'b1);
        chk("dir1_lock",  OUT_LOCK,  1'b0);
        send_raw(4'b0000, 1'b0);
        chk("dir2_d",     OUT_D,     4'b1100);
        chk("dir2_lock",  OUT_LOCK,  1'b0);
        @(posedge CLK);
        #1;
        chk("drain_valid", OUT_VALID, 1'b0);

        // Round trip through a reference scrambler seeded 7'h55.
        do_reset();
        scr_st = 7'h55;
        for (int i = 0; i < 64; i++) begin
            p = 4'($urandom_range(0, 15));
            send_plain(p);
            chk("rt_valid", OUT_VALID, 1'b1);
            if (i >= 2) begin
                chk("rt_data", OUT_D,    p);
                chk("rt_lock", OUT_LOCK, 1'b1);
            end else begin
                chk("rt_prelock", OUT_LOCK, 1'b0);
            end
        end

        // Backpressure: hold B for 5 stalled cycles behind A.
        pa = 4'hA;
        send_plain(pa);
        chk("bp_a", OUT_D, pa);
        pb = 4'h3;
        scramble(pb, scr_st, s, nst);
        IN_D      = s;
        IN_PAR    = ^s;
        IN_VALID  = 1'b1;
        OUT_READY = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            chk("bp_in_ready", IN_READY,  1'b0);
            chk("bp_hold_d",   OUT_D,     pa);
            chk("bp_hold_v",   OUT_VALID, 1'b1);
        end
        OUT_READY = 1'b1;
        #1;
        chk("bp_release_rdy", IN_READY, 1'b1);
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        scr_st   = nst;
        chk("bp_b",      OUT_D,    pb);
        chk("bp_b_lock", OUT_LOCK, 1'b1);
        pc = 4'h6;
        send_plain(pc);
        chk("bp_c", OUT_D, pc);

        // Asynchronous reset mid-transfer drops pending output and relocks.
        do_reset();
        scr_st = 7'h2A;
        for (int i = 0; i < 10; i++) begin
            send_plain(4'($urandom_range(0, 15)));
        end
        chk("mid_pre_lock", OUT_LOCK, 1'b1);
        scramble(4'h9, scr_st, s, nst);
        IN_D     = s;
        IN_PAR   = ^s;
        IN_VALID = 1'b1;
        #2;
        RST = 1'b1;
        #1;
        chk("mid_rst_d",     OUT_D,     4'h0);
        chk("mid_rst_valid", OUT_VALID, 1'b0);
        chk("mid_rst_lock",  OUT_LOCK,  1'b0);
        chk("mid_rst_rdy",   IN_READY,  1'b1);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        IN_VALID = 1'b0;
        scr_st   = nst;
        chk("relock_1", OUT_LOCK, 1'b0);
        send_plain(4'h4);
        chk("relock_2", OUT_LOCK, 1'b0);
        send_plain(4'hE);
        chk("relock_3",   OUT_LOCK, 1'b1);
        chk("relock_3_d", OUT_D,    4'hE);

        // Parity: 0111 with IN_PAR=0 is a mismatch; data path unaffected.
        do_reset();
        send_raw(4'b0111, 1'b0);
        chk("par_d",   OUT_D,   4'b0111);
        chk("par_err", PAR_ERR, PAR_ON);
        chk("par_cnt", ERR_CNT, PAR_ON ? 4'd1 : 4'd0);
        send_raw(4'b0110, 1'b0);
        chk("par_ok_err", PAR_ERR, 1'b0);
        chk("par_ok_cnt", ERR_CNT, PAR_ON ? 4'd1 : 4'd0);
        for (int i = 0; i < 20; i++) begin
            send_raw(4'b0111, 1'b0);
        end
        chk("par_sat_err", PAR_ERR, PAR_ON);
        chk("par_sat_cnt", ERR_CNT, PAR_ON ? 4'd15 : 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/w_xor_descrambler.md
# w_xor_descrambler

4-bit-wide self-synchronizing descrambler for the XOR-gate lab series. It recovers plaintext nibbles from a stream produced by a matching x^7+x^6+1 XOR scrambler, the receive end of that link. It sits between a nibble-wide serial front end and downstream logic. It has valid/ready handshakes on both sides and a one-stage registered output.

## Interface
- No parameters. Polynomial x^7+x^6+1, data width 4, and lock threshold are fixed.
- CLK  in  1  rising-edge clock, single domain
- RST  in  1  asynchronous, active-high reset
- IN_D  in  4  scrambled nibble; bit 0 is earliest in the serial order
- IN_PAR  in  1  even parity over IN_D; used only with PARITY_CHECK_EN
- IN_VALID  in  1  IN_D/IN_PAR valid
- IN_READY  out  1  block accepts a nibble this cycle
- OUT_D  out  4  descrambled nibble
- OUT_VALID  out  1  OUT_D valid
- OUT_READY  in  1  downstream accepts OUT_D
- OUT_LOCK  out  1  OUT_D comes from a fully primed shift register
- PAR_ERR  out  1  parity mismatch on the nibble now in OUT_D
- ERR_CNT  out  4  saturating count of parity errors

## Operation
- A transfer happens when IN_VALID && IN_READY.
- IN_READY = !OUT_VALID || OUT_READY. This is combinational, with no skid buffer.
- The 7-bit history register SR holds the last 7 received scrambled bits; SR[0] is the most recent.
- On each accepted nibble, process bits b = 0..3 in order:
  - y[b] = IN_D[b] ^ SR[6] ^ SR[5]
  - then SR = {SR[5:0], IN_D[b]}
- The four updates are unrolled within one cycle. The final SR is registered. y is loaded into OUT_D.
- Lock counter: 2-bit saturating count of accepted nibbles. OUT_LOCK is registered with OUT_D and equals 1 when the nibble is the 3rd or later accepted since reset. By then 8 or more bits have been shifted in, so SR is fully primed for every bit of that nibble.
- Pre-lock nibbles are still emitted, with OUT_LOCK = 0.
- OUT_VALID:
  - sets on a transfer
  - clears when OUT_READY is high and there is no new transfer
  - stays set on simultaneous pop+push, with OUT_D replaced
- With OUT_VALID = 1 and OUT_READY = 0, OUT_D, OUT_LOCK and PAR_ERR hold. IN_READY = 0.
- SR advances only on a transfer. Stalls never corrupt the history.

## Timing
- Latency: accepted on edge N, visible on OUT_D after edge N, i.e. 1 cycle.
- Throughput: 1 nibble/cycle while OUT_READY = 1.
- Reset values: OUT_D = 0, OUT_VALID = 0, OUT_LOCK = 0, PAR_ERR = 0, ERR_CNT = 0, SR = 0, lock count = 0.
- IN_READY is 1 during and after reset, because OUT_VALID = 0.
- Reset asserted mid-stream:
  - all state clears immediately and asynchronously
  - any pending OUT_D is dropped
  - relock requires 2 new nibbles

## Configuration
- PARITY_CHECK_EN defined:
  - PAR_ERR = (^IN_D) ^ IN_PAR, registered with OUT_D
  - ERR_CNT increments on each accepted nibble with a mismatch, saturating at 15
  - mismatches are counted regardless of OUT_LOCK
- PARITY_CHECK_EN undefined:
  - IN_PAR is ignored
  - PAR_ERR and ERR_CNT are constant 0
  - no parity logic is synthesized
  - ports remain present in both configurations

## Structure
- The shared package holds the SR width (7), tap indices (5, 6), data width (4), lock threshold (2), and ERR_CNT width (4).
- One sub-module, w_xor_descr_step, is the natural split: a combinational single-bit step (d, SR in → y, SR out), instantiated 4× in a chain.
- The handshake, lock counter and parity logic live in the top level.

## Test plan
- Reset, then input 4'b0001, then 4'b0000 with OUT_READY = 1 → OUT_D = 4'b0001 with OUT_LOCK = 0, then 4'b1100 with OUT_LOCK = 0.
- Round trip: a reference scrambler, seed 7'h55, carries 64 random nibbles → from the 3rd output onward OUT_D matches the plaintext and OUT_LOCK = 1.
- Backpressure:
  - hold OUT_READY = 0 for 5 cycles with IN_VALID = 1 → IN_READY = 0 and OUT_D stable
  - release → stream continues correctly with no nibble lost or duplicated
- Assert RST after 10 nibbles mid-transfer → outputs return to 0 at once; the next 2 outputs have OUT_LOCK = 0.
- PARITY_CHECK_EN: input IN_D = 4'b0111 with IN_PAR = 0 → PAR_ERR = 1, ERR_CNT = 1; 20 bad nibbles → ERR_CNT = 15, saturated.
- Without PARITY_CHECK_EN: the same stimulus → PAR_ERR = 0, ERR_CNT = 0, and data is unaffected.
